// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {OWN_D, OWN_I} owner_t;

    localparam logic [2:0] FUNC3_LW = 3'b010;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: bit 0 is the data port, bit 1 the fetch port.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_owner,
    output logic [1:0] grant,
    output logic       valid
);

    always_comb begin
        grant = req;
        valid = |req;
        // On a tie, the port that did not win last time goes first.
        if (req == 2'b11) begin
            grant = (last_owner == OWN_D) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one single-ported data memory between the MEM-stage port (D) and the fetch port (I),
// sequencing each access over MEM_LATENCY cycles and returning registered read data.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              D_Read,
    input  logic              D_Write,
    input  logic [ADDR_W-1:0] D_Address,
    input  logic [31:0]       D_Write_data,
    input  logic [2:0]        D_Func3,
    output logic [31:0]       D_Read_data,
    output logic              D_busywait,
    input  logic              I_Read,
    input  logic [ADDR_W-1:0] I_Address,
    output logic [31:0]       I_Read_data,
    output logic              I_busywait,
    output logic              M_Read,
    output logic              M_Write,
    output logic [ADDR_W-1:0] M_Address,
    output logic [31:0]       M_Write_data,
    output logic [2:0]        M_Func3,
    input  logic [31:0]       M_Read_data
);

    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    owner_t            owner, last_owner;
    logic              acc_write;
    logic [ADDR_W-1:0] acc_addr;
    logic [31:0]       acc_wdata;
    logic [2:0]        acc_func3;

    logic       d_valid, i_valid;
    logic [1:0] grant;
    logic       arb_valid;
    logic       take;

    // A simultaneous load and store on the data port is treated as no request.
    assign d_valid = D_Read ^ D_Write;
    assign i_valid = I_Read;
    assign take    = (state == IDLE) && arb_valid;

    rr_arb2 u_rr_arb2 (
        .req        ({i_valid, d_valid}),
        .last_owner (last_owner),
        .grant      (grant),
        .valid      (arb_valid)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_valid) state_nxt = ACCESS;
            ACCESS:  if (cnt == '0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            cnt         <= '0;
            owner       <= OWN_D;
            last_owner  <= OWN_I;
            acc_write   <= 1'b0;
            D_Read_data <= '0;
            I_Read_data <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        owner      <= grant[1] ? OWN_I : OWN_D;
                        last_owner <= grant[1] ? OWN_I : OWN_D;
                        acc_write  <= grant[0] & D_Write;
                        cnt        <= CNT_W'(MEM_LATENCY - 1);
                    end
                end
                ACCESS: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                RESP: begin
                    if (!acc_write) begin
                        if (owner == OWN_D) D_Read_data <= M_Read_data;
                        else                I_Read_data <= M_Read_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // Request payload is captured once at grant; the memory side only sees these copies.
    always_ff @(posedge Clock) begin
        if (take) begin
            acc_addr  <= grant[0] ? D_Address : I_Address;
            acc_wdata <= D_Write_data;
            acc_func3 <= grant[0] ? D_Func3 : FUNC3_LW;
        end
    end

    always_comb begin
        M_Read       = 1'b0;
        M_Write      = 1'b0;
        M_Address    = '0;
        M_Write_data = '0;
        M_Func3      = '0;
        if (state == ACCESS || state == RESP) begin
            M_Address    = acc_addr;
            M_Write_data = acc_wdata;
            M_Func3      = acc_func3;
            M_Read       = ~acc_write;
            M_Write      = acc_write & (state == ACCESS);
        end
    end

    assign D_busywait = d_valid & ~((state == RESP) && (owner == OWN_D));
    assign I_busywait = i_valid & ~((state == RESP) && (owner == OWN_I));

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter with an address-derived memory model.
module tb_dmem_port_arbiter;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        D_Read = 1'b0, D_Write = 1'b0;
    logic [31:0] D_Address = '0, D_Write_data = '0;
    logic [2:0]  D_Func3 = 3'b010;
    logic [31:0] D_Read_data;
    logic        D_busywait;
    logic        I_Read = 1'b0;
    logic [31:0] I_Address = '0;
    logic [31:0] I_Read_data;
    logic        I_busywait;
    logic        M_Read, M_Write;
    logic [31:0] M_Address, M_Write_data;
    logic [2:0]  M_Func3;
    logic [31:0] M_Read_data;

    dmem_port_arbiter #(.MEM_LATENCY(2), .ADDR_W(32)) dut (
        .Clock(Clock), .Reset(Reset),
        .D_Read(D_Read), .D_Write(D_Write), .D_Address(D_Address),
        .D_Write_data(D_Write_data), .D_Func3(D_Func3),
        .D_Read_data(D_Read_data), .D_busywait(D_busywait),
        .I_Read(I_Read), .I_Address(I_Address),
        .I_Read_data(I_Read_data), .I_busywait(I_busywait),
        .M_Read(M_Read), .M_Write(M_Write), .M_Address(M_Address),
        .M_Write_data(M_Write_data), .M_Func3(M_Func3), .M_Read_data(M_Read_data)
    );

    always #5 Clock = ~Clock;

    function automatic logic [31:0] mw(input logic [31:0] a);
        return 32'hD000_0000 ^ ((a >> 2) * 32'h0001_0003);
    endfunction

    assign M_Read_data = mw(M_Address);

    int          total = 0, bad = 0;
    logic [31:0] d_exp[$], i_exp[$];
    bit          g_exp[$];
    int          rd_cnt = 0, wr_cnt = 0;
    logic [31:0] w_addr = '0, w_data = '0;
    logic [2:0]  w_f3 = '0;
    bit          prev_act = 0, d_pend = 0, i_pend = 0;
    int          nd, ni, r0, w0, dbw;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Sampled on the falling edge: memory activity, grant order and returned read data.
    task automatic mon_step();
        bit act;
        if (d_pend) begin
            chk("d_rd_queued", 32'(d_exp.size() != 0), 1);
            if (d_exp.size() != 0) chk("d_rdata", D_Read_data, d_exp.pop_front());
        end
        if (i_pend) begin
            chk("i_rd_queued", 32'(i_exp.size() != 0), 1);
            if (i_exp.size() != 0) chk("i_rdata", I_Read_data, i_exp.pop_front());
        end
        if (M_Read) rd_cnt++;
        if (M_Write) begin
            wr_cnt++;
            w_addr = M_Address;
            w_data = M_Write_data;
            w_f3   = M_Func3;
        end
        act = M_Read | M_Write;
        if (act && !prev_act) begin
            chk("grant_queued", 32'(g_exp.size() != 0), 1);
            if (g_exp.size() != 0) chk("grant_owner", 32'(M_Address[15]), 32'(g_exp.pop_front()));
        end
        prev_act = act;
        d_pend = !Reset && D_Read && !D_Write && !D_busywait;
        i_pend = !Reset && I_Read && !I_busywait;
    endtask

    task automatic d_reads(input logic [31:0] base, input int cnt, output int n_first);
        int n;
        n_first = 0;
        D_Read = 1'b1; D_Write = 1'b0; D_Func3 = 3'b010;
        for (int k = 0; k < cnt; k++) begin
            D_Address = base + 32'(4 * k);
            d_exp.push_back(mw(base + 32'(4 * k)));
            n = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge Clock);
                n++;
                if (!D_busywait) break;
            end
            chk("d_done", D_busywait, 0);
            if (k == 0) n_first = n;
            @(posedge Clock); #1;
        end
        D_Read = 1'b0;
    endtask

    task automatic i_reads(input logic [31:0] base, input int cnt, output int n_first);
        int n;
        n_first = 0;
        I_Read = 1'b1;
        for (int k = 0; k < cnt; k++) begin
            I_Address = base + 32'(4 * k);
            i_exp.push_back(mw(base + 32'(4 * k)));
            n = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge Clock);
                n++;
                if (!I_busywait) break;
            end
            chk("i_done", I_busywait, 0);
            if (k == 0) n_first = n;
            @(posedge Clock); #1;
        end
        I_Read = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b0;
    endtask

    initial begin
        fork
            forever begin
                @(negedge Clock);
                mon_step();
            end
        join_none

        Reset = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_mread", M_Read, 0);
        chk("rst_mwrite", M_Write, 0);
        chk("rst_maddr", M_Address, 0);
        chk("rst_drdata", D_Read_data, 0);
        chk("rst_irdata", I_Read_data, 0);
        chk("rst_dbw", D_busywait, 0);
        Reset = 1'b0;
        @(posedge Clock); #1;

        // Lone data load
        g_exp.push_back(1'b0);
        r0 = rd_cnt;
        d_reads(32'h40, 1, nd);
        chk("t1_latency", nd, 4);
        chk("t1_mread_cyc", rd_cnt - r0, 3);
        repeat (2) @(posedge Clock); #1;

        // Tie straight after reset: data port first
        do_reset();
        g_exp.push_back(1'b0);
        g_exp.push_back(1'b1);
        fork
            d_reads(32'h100, 1, nd);
            i_reads(32'h8000, 1, ni);
        join
        chk("t2_d_latency", nd, 4);
        chk("t2_i_span", ni, 8);

        // Sustained contention alternates ports
        g_exp.push_back(1'b0); g_exp.push_back(1'b1);
        g_exp.push_back(1'b0); g_exp.push_back(1'b1);
        fork
            d_reads(32'h200, 2, nd);
            i_reads(32'h8010, 2, ni);
        join
        repeat (2) @(posedge Clock); #1;

        // Byte store
        g_exp.push_back(1'b0);
        w0 = wr_cnt;
        D_Write = 1'b1; D_Read = 1'b0; D_Address = 32'h43;
        D_Write_data = 32'h0000_00A5; D_Func3 = 3'b000;
        nd = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge Clock);
            nd++;
            if (!D_busywait) break;
        end
        chk("t4_done", D_busywait, 0);
        @(posedge Clock); #1;
        D_Write = 1'b0;
        chk("t4_latency", nd, 4);
        chk("t4_mwrite_cyc", wr_cnt - w0, 2);
        chk("t4_waddr", w_addr, 32'h43);
        chk("t4_wdata", w_data, 32'h0000_00A5);
        chk("t4_func3", 32'(w_f3), 0);
        chk("t4_irdata_kept", I_Read_data, mw(32'h8014));

        // Conflicting load+store on D is ignored; fetch still served
        g_exp.push_back(1'b1);
        w0 = wr_cnt;
        dbw = 0;
        D_Read = 1'b1; D_Write = 1'b1; D_Address = 32'h1000; D_Func3 = 3'b010;
        fork
            i_reads(32'h8100, 1, ni);
            begin
                repeat (6) begin
                    @(negedge Clock);
                    if (D_busywait) dbw++;
                end
            end
        join
        D_Read = 1'b0; D_Write = 1'b0;
        chk("t5_i_latency", ni, 4);
        chk("t5_dbw_high", dbw, 0);
        chk("t5_no_write", wr_cnt - w0, 0);
        repeat (2) @(posedge Clock); #1;

        // Async reset in the middle of a fetch, with a data load waiting
        I_Read = 1'b1; I_Address = 32'h8200;
        @(posedge Clock);
        #2;
        D_Read = 1'b1; D_Write = 1'b0; D_Address = 32'h1200; D_Func3 = 3'b010;
        d_exp.push_back(mw(32'h1200));
        g_exp.push_back(1'b0);
        #1;
        chk("t6_mread_pre", M_Read, 1);
        Reset = 1'b1;
        I_Read = 1'b0;
        #1;
        chk("t6_mread_rst", M_Read, 0);
        chk("t6_irdata_rst", I_Read_data, 0);
        chk("t6_drdata_rst", D_Read_data, 0);
        chk("t6_dbw_rst", D_busywait, 1);
        @(negedge Clock);
        #2 Reset = 1'b0;
        @(posedge Clock); #1;
        chk("t6_d_grant", M_Read, 1);
        chk("t6_d_addr", M_Address, 32'h1200);
        nd = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge Clock);
            nd++;
            if (!D_busywait) break;
        end
        chk("t6_d_done", D_busywait, 0);
        chk("t6_d_remaining", nd, 3);
        @(posedge Clock); #1;
        D_Read = 1'b0;
        repeat (3) @(posedge Clock); #1;

        chk("left_grants", g_exp.size(), 0);
        chk("left_d_reads", d_exp.size(), 0);
        chk("left_i_reads", i_exp.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
